// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control unit and its multiply/divide engine.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [5:0] FUNC_ADD     = 6'b100000;
  localparam logic [5:0] FUNC_SUB     = 6'b100010;
  localparam logic [5:0] FUNC_AND     = 6'b100100;
  localparam logic [5:0] FUNC_OR      = 6'b100101;
  localparam logic [5:0] FUNC_XOR     = 6'b100110;
  localparam logic [5:0] FUNC_NOR     = 6'b100111;
  localparam logic [5:0] FUNC_SLT     = 6'b101010;
  localparam logic [5:0] FUNC_SLT_ALT = 6'b110010;
  localparam logic [5:0] FUNC_MULT    = 6'b011000;
  localparam logic [5:0] FUNC_MULTU   = 6'b011001;
  localparam logic [5:0] FUNC_DIV     = 6'b011010;
  localparam logic [5:0] FUNC_DIVU    = 6'b011011;
  localparam logic [5:0] FUNC_MFHI    = 6'b010000;
  localparam logic [5:0] FUNC_MTHI    = 6'b010001;
  localparam logic [5:0] FUNC_MFLO    = 6'b010010;
  localparam logic [5:0] FUNC_MTLO    = 6'b010011;

  localparam logic [2:0] ALUCTRL_AND = 3'b000;
  localparam logic [2:0] ALUCTRL_OR  = 3'b001;
  localparam logic [2:0] ALUCTRL_ADD = 3'b010;
  localparam logic [2:0] ALUCTRL_XOR = 3'b011;
  localparam logic [2:0] ALUCTRL_NOR = 3'b100;
  localparam logic [2:0] ALUCTRL_SUB = 3'b110;
  localparam logic [2:0] ALUCTRL_SLT = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_PREP = 2'd1,
    MD_RUN  = 2'd2,
    MD_FIX  = 2'd3
  } md_state_e;

  function automatic logic is_md_class(input logic [5:0] f);
    return f inside {FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU,
                     FUNC_MFHI, FUNC_MTHI, FUNC_MFLO, FUNC_MTLO};
  endfunction

  function automatic logic is_muldiv(input logic [5:0] f);
    return f inside {FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU};
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative multiply/divide datapath: one result bit per cycle, signs handled
// around an unsigned core.
//
// state   | meaning
// --------+-----------------------------------------------------------
// MD_IDLE | waiting for start; operands captured on the start edge
// MD_PREP | form operand magnitudes, record result signs, load counter
// MD_RUN  | WIDTH iterations of shift-add / restoring shift-subtract
// MD_FIX  | signed/special-case result presented; done pulses next cycle
module md_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             idle,
  output logic             fix,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_e state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_cap, b_cap;
  logic             div_r, sgn_r;
  logic             neg_res, neg_rem;
  logic [WIDTH-1:0] m, q, rem;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic               div_ge;
  logic [WIDTH-1:0]   sub;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo, rmd;

  assign mag_a   = (sgn_r && a_cap[WIDTH-1]) ? -a_cap : a_cap;
  assign mag_b   = (sgn_r && b_cap[WIDTH-1]) ? -b_cap : b_cap;
  assign mul_sum = {1'b0, rem} + (q[0] ? {1'b0, m} : '0);
  assign shifted = {rem, q[WIDTH-1]};
  assign div_ge  = shifted >= {1'b0, m};
  assign sub     = WIDTH'(shifted - {1'b0, m});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      a_cap   <= '0;
      b_cap   <= '0;
      div_r   <= 1'b0;
      sgn_r   <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      m       <= '0;
      q       <= '0;
      rem     <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == MD_FIX);
      case (state)
        MD_IDLE: begin
          if (start) begin
            a_cap <= src_a;
            b_cap <= src_b;
            div_r <= op_div;
            sgn_r <= op_signed;
          end
        end
        MD_PREP: begin
          m       <= mag_b;
          q       <= mag_a;
          rem     <= '0;
          cnt     <= CNT_W'(WIDTH);
          neg_res <= sgn_r & (a_cap[WIDTH-1] ^ b_cap[WIDTH-1]);
          neg_rem <= sgn_r & a_cap[WIDTH-1];
        end
        MD_RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (div_r) begin
            rem <= div_ge ? sub : shifted[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], div_ge};
          end else begin
            rem <= mul_sum[WIDTH:1];
            q   <= {mul_sum[0], q[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (start) state_next = MD_PREP;
      MD_PREP: state_next = MD_RUN;
      MD_RUN:  if (cnt == CNT_W'(1)) state_next = MD_FIX;
      MD_FIX:  state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  // Overflow (-2^(W-1) / -1) falls out naturally: the magnitude quotient
  // 2^(W-1) is not negated, which is exactly the required 0x80..0.
  always_comb begin
    prod     = {rem, q};
    prod_fix = neg_res ? -prod : prod;
    quo      = neg_res ? -q : q;
    rmd      = neg_rem ? -rem : rem;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (div_r) begin
      if (b_cap == '0) begin
        res_hi = a_cap;
        res_lo = '1;
      end else begin
        res_hi = rmd;
        res_lo = quo;
      end
    end
  end

  assign idle = (state == MD_IDLE);
  assign fix  = (state == MD_FIX);

endmodule

// File: rtl/alu_control_md.sv
// ALU control decode plus HI/LO ownership and pipeline stall for the
// multi-cycle multiply/divide engine.
module alu_control_md
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        func,
  input  logic              op_valid,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  output logic [CTRL_W-1:0] ALUControl,
  output logic [WIDTH-1:0]  hilo_rdata,
  output logic              md_busy,
  output logic              md_done,
  output logic              stall
);

  logic             rtype, md_class, muldiv, start;
  logic             idle, fix;
  logic [WIDTH-1:0] hi, lo, res_hi, res_lo;
  logic [2:0]       ctrl;

  assign rtype    = (ALUOp == ALUOP_RTYPE);
  assign md_class = rtype & is_md_class(func);
  assign muldiv   = rtype & is_muldiv(func);
  assign start    = op_valid & muldiv & idle;
  assign stall    = op_valid & md_class & ~idle;
  assign md_busy  = ~idle;

  always_comb begin
    ctrl = ALUCTRL_AND;
    case (ALUOp)
      ALUOP_ADD: ctrl = ALUCTRL_ADD;
      ALUOP_SUB: ctrl = ALUCTRL_SUB;
      ALUOP_AND: ctrl = ALUCTRL_AND;
      default: begin
        case (func)
          FUNC_ADD:               ctrl = ALUCTRL_ADD;
          FUNC_SUB:               ctrl = ALUCTRL_SUB;
          FUNC_AND:               ctrl = ALUCTRL_AND;
          FUNC_OR:                ctrl = ALUCTRL_OR;
          FUNC_XOR:               ctrl = ALUCTRL_XOR;
          FUNC_NOR:               ctrl = ALUCTRL_NOR;
          FUNC_SLT, FUNC_SLT_ALT: ctrl = ALUCTRL_SLT;
          default:                ctrl = ALUCTRL_AND;
        endcase
      end
    endcase
  end

  assign ALUControl = CTRL_W'(ctrl);

  always_comb begin
    hilo_rdata = '0;
    if (rtype && idle) begin
      if (func == FUNC_MFHI) hilo_rdata = hi;
      if (func == FUNC_MFLO) hilo_rdata = lo;
    end
  end

  // Engine results and mthi/mtlo are mutually exclusive: moves only land in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (fix) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (op_valid && rtype && idle) begin
      if (func == FUNC_MTHI) hi <= src_a;
      if (func == FUNC_MTLO) lo <= src_a;
    end
  end

  md_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_div    (func[1]),
    .op_signed (~func[0]),
    .src_a     (src_a),
    .src_b     (src_b),
    .idle      (idle),
    .fix       (fix),
    .done      (md_done),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

endmodule

// File: tb/tb_alu_control_md.sv
// Directed and randomized checks of alu_control_md against an arithmetic reference model.
module tb_alu_control_md;

  localparam int W = 32;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   ALUOp;
  logic [5:0]   func;
  logic         op_valid;
  logic [W-1:0] src_a, src_b;
  logic [2:0]   ALUControl;
  logic [W-1:0] hilo_rdata;
  logic         md_busy, md_done, stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_control_md #(.WIDTH(W), .CTRL_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ALUOp      (ALUOp),
    .func       (func),
    .op_valid   (op_valid),
    .src_a      (src_a),
    .src_b      (src_b),
    .ALUControl (ALUControl),
    .hilo_rdata (hilo_rdata),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .stall      (stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 3'b010;
    if (op == 2'b01) return 3'b110;
    if (op == 2'b11) return 3'b000;
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100110: return 3'b011;
      6'b100111: return 3'b100;
      6'b101010, 6'b110010: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic void md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
    longint sp;
    logic [63:0] up;
    int sa, sb;
    sa = a;
    sb = b;
    hi = '0;
    lo = '0;
    case (f)
      F_MULT: begin
        sp = longint'(sa) * longint'(sb);
        {hi, lo} = sp;
      end
      F_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {hi, lo} = up;
      end
      F_DIV: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 0; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      default: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctrl(input logic [1:0] op, input logic [5:0] f, input logic [2:0] exp);
    ALUOp = op;
    func = f;
    #1;
    chk("alucontrol", ALUControl, exp);
  endtask

  // Entered and left at one time unit after a rising edge.
  task automatic do_md(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    ALUOp = 2'b10;
    func = f;
    src_a = a;
    src_b = b;
    op_valid = 1'b1;
    sync();
    op_valid = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    chk({tag, " busy"}, md_busy, 1);
    cyc = 0;
    while (md_done !== 1'b1 && cyc < W + 20) begin
      sync();
      cyc++;
    end
    chk({tag, " latency"}, cyc, W + 2);
    op_valid = 1'b1;
    func = F_MFHI;
    #1;
    chk({tag, " hi"}, hilo_rdata, exp_hi);
    func = F_MFLO;
    #1;
    chk({tag, " lo"}, hilo_rdata, exp_lo);
    op_valid = 1'b0;
    sync();
    chk({tag, " done_pulse"}, md_done, 0);
  endtask

  initial begin
    logic [31:0] eh, el, a, b, last_lo;
    logic [5:0]  f;
    int cyc;
    logic seen;

    ALUOp = 2'b00; func = 6'd0; op_valid = 1'b0; src_a = '0; src_b = '0;

    // reset state
    #12;
    chk("rst busy", md_busy, 0);
    chk("rst done", md_done, 0);
    ALUOp = 2'b10; func = F_MFLO; op_valid = 1'b1;
    #1;
    chk("rst stall", stall, 0);
    chk("rst lo", hilo_rdata, 0);
    op_valid = 1'b0;
    sync();
    rst_n = 1'b1;
    sync();

    // ALUControl decode
    chk_ctrl(2'b10, 6'b100111, 3'b100);
    chk_ctrl(2'b10, 6'b101010, 3'b111);
    chk_ctrl(2'b10, 6'b110010, 3'b111);
    chk_ctrl(2'b10, 6'b111111, 3'b000);
    chk_ctrl(2'b10, 6'b100110, 3'b011);
    chk_ctrl(2'b10, 6'b100101, 3'b001);
    chk_ctrl(2'b01, 6'b100101, 3'b110);
    chk_ctrl(2'b00, 6'b100010, 3'b010);
    chk_ctrl(2'b11, 6'b100000, 3'b000);
    for (int i = 0; i < 16; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      f = 6'($urandom);
      chk_ctrl(op, f, ref_ctrl(op, f));
    end
    sync();

    // directed multiply/divide
    do_md("mult", F_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_md("multu", F_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA);
    do_md("div", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_md("divu0", F_DIVU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
    do_md("divovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // mflo held across a divide, with an add slipped in mid-run
    a = $urandom; b = $urandom_range(1, 1000);
    md_model(F_DIV, a, b, eh, el);
    ALUOp = 2'b10; func = F_DIV; src_a = a; src_b = b; op_valid = 1'b1;
    sync();
    for (int i = 0; i < W + 2; i++) begin
      func = (i == 10) ? F_ADD : F_MFLO;
      #1;
      if (i == 10) begin
        chk("add stall", stall, 0);
        chk("add ctrl", ALUControl, 3'b010);
      end else begin
        chk("mflo stall", stall, 1);
      end
      sync();
    end
    func = F_MFLO;
    #1;
    chk("mflo release stall", stall, 0);
    chk("mflo release done", md_done, 1);
    chk("mflo value", hilo_rdata, el);
    op_valid = 1'b0;
    sync();

    // mthi in idle, then mthi held while busy
    ALUOp = 2'b10; func = F_MTHI; src_a = 32'h1234_5678; op_valid = 1'b1;
    sync();
    func = F_MFHI;
    #1;
    chk("mthi idle", hilo_rdata, 32'h1234_5678);
    op_valid = 1'b0;
    sync();
    a = $urandom; b = $urandom;
    md_model(F_MULT, a, b, eh, el);
    func = F_MULT; src_a = a; src_b = b; op_valid = 1'b1;
    sync();
    func = F_MTHI; src_a = 32'hDEAD_BEEF;
    #1;
    chk("mthi busy stall", stall, 1);
    cyc = 0;
    while (md_done !== 1'b1 && cyc < W + 20) begin
      sync();
      cyc++;
    end
    chk("mthi busy latency", cyc, W + 2);
    func = F_MFHI;
    #1;
    chk("mthi blocked hi", hilo_rdata, eh);
    func = F_MTHI;
    sync();
    func = F_MFHI;
    #1;
    chk("mthi after idle", hilo_rdata, 32'hDEAD_BEEF);
    op_valid = 1'b0;
    sync();

    // reset mid-run
    a = $urandom; b = $urandom;
    func = F_MULTU; src_a = a; src_b = b; op_valid = 1'b1;
    sync();
    op_valid = 1'b0;
    repeat (11) sync();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", md_busy, 0);
    chk("abort done", md_done, 0);
    op_valid = 1'b1; func = F_MFHI;
    #1;
    chk("abort hi", hilo_rdata, 0);
    func = F_MFLO;
    #1;
    chk("abort lo", hilo_rdata, 0);
    op_valid = 1'b0;
    sync();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      sync();
      if (md_done === 1'b1) seen = 1'b1;
    end
    chk("abort no done", seen, 0);
    a = $urandom; b = $urandom;
    md_model(F_MULT, a, b, eh, el);
    do_md("post_abort", F_MULT, a, b, eh, el);
    last_lo = el;

    // op_valid low: no start, no move
    ALUOp = 2'b10; func = F_MULT; op_valid = 1'b0; src_a = $urandom; src_b = $urandom;
    sync();
    chk("novalid busy", md_busy, 0);
    func = F_MTLO; src_a = 32'hAAAA_5555;
    #1;
    chk("novalid stall", stall, 0);
    sync();
    func = F_MFLO; op_valid = 1'b1;
    #1;
    chk("novalid lo", hilo_rdata, last_lo);
    op_valid = 1'b0;
    sync();

    // randomized operations with forced corners
    for (int k = 0; k < 14; k++) begin
      case ($urandom_range(0, 3))
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_DIV;
        default: f = F_DIVU;
      endcase
      a = $urandom;
      b = ((k % 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (k % 5 == 3) b = 32'd0;
      if (k % 7 == 4) begin f = F_DIV; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (k % 4 == 1 && f[1]) b = -b;
      md_model(f, a, b, eh, el);
      do_md("rand", f, a, b, eh, el);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_control_md.md
Name: alu_control_md

Overview:
- Next-generation ALU control unit. Decodes ALUOp/func into ALUControl as before, with an extended func set.
- Adds a parametrised multi-cycle multiply/divide engine owning the HI/LO registers.
- Drives a stall handshake to the pipeline control while the engine is busy.
- Sits between the main decoder/register file and the ALU in the datapath.

Parameters:
WIDTH, 32, operand and HI/LO register width (>=4, even)
CTRL_W, 3, ALUControl width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
ALUOp  in  2  from main decoder
func  in  6  instruction bits [5:0]
op_valid  in  1  current instruction is valid (not a bubble)
src_a  in  WIDTH  rs operand (dividend / multiplicand / mthi/mtlo data)
src_b  in  WIDTH  rt operand (divisor / multiplier)
ALUControl  out  CTRL_W  ALU operation select
hilo_rdata  out  WIDTH  HI for mfhi, LO for mflo, else 0
md_busy  out  1  engine iterating
md_done  out  1  one-cycle pulse when HI/LO are updated by mult/div
stall  out  1  hold the pipeline this cycle

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; HI=LO=0; iteration counter=0; md_busy=0; md_done=0. Combinational outputs follow the inputs once reset releases; stall=0 while in reset.
- ALUControl (combinational):
  - ALUOp 00 -> 010; ALUOp 01 -> 110; ALUOp 11 -> 000.
  - ALUOp 10 by func: 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 100110 -> 011 (xor); 100111 -> 100 (nor); 101010 and 110010 -> 111 (slt); all other func -> 000.
- Engine func codes (ALUOp=10 only): mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011. Call these MD-class.
- start = op_valid & ALUOp==10 & func in {mult,multu,div,divu} & FSM==IDLE. Operands are captured at this edge.
- FSM states and transitions:
  - IDLE: on start -> PREP.
  - PREP: 1 cycle. Signed ops take magnitudes of src_a/src_b and record quotient and remainder signs -> RUN.
  - RUN: exactly WIDTH cycles, one bit per cycle. Shift-add for multiply; restoring shift-subtract for divide -> FIX.
  - FIX: 1 cycle. Apply signs, write HI/LO, pulse md_done -> IDLE.
- Latency: md_done is high in the cycle WIDTH+2 clocks after the start edge. md_busy is high in PREP, RUN and FIX.
- Results:
  - mult/multu: {HI,LO} = 2*WIDTH-bit product.
  - div/divu: LO = quotient, HI = remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: still full latency. LO = all ones, HI = src_a as captured.
- Signed overflow (-2^(WIDTH-1) / -1): LO = 0x80..0, HI = 0. No trap.
- stall = op_valid & ALUOp==10 & func MD-class & (FSM != IDLE). The pipeline re-presents the same instruction until stall drops.
- A new mult/div presented in the FIX cycle stalls; it is accepted the next cycle.
- mthi/mtlo: write src_a to HI/LO at the edge when op_valid and FSM==IDLE; no effect while stalled.
- mfhi/mflo: hilo_rdata is combinational from HI/LO when FSM==IDLE; otherwise 0, and stall is asserted.
- Non-MD instructions never stall and proceed while the engine runs.
- rst_n asserted mid-operation aborts immediately: HI/LO=0, no md_done.
- op_valid=0: no start, no HI/LO write, stall=0.

Decomposition:
- Shared package alu_pkg:
  - ALUOP_* constants (2 bit).
  - FUNC_* constants (6 bit).
  - ALUCTRL_* codes: AND=000, OR=001, ADD=010, XOR=011, NOR=100, SUB=110, SLT=111.
  - FSM state encoding (IDLE, PREP, RUN, FIX).
- One sub-module, md_iter_core: PREP/RUN/FIX datapath and counter, with a start/done handshake and WIDTH parameter.
- Decode and stall logic stays in the top.

Test Plan:
- ALUOp=10, func=100111 / 101010 / 110010 / 111111 -> ALUControl=100 / 111 / 111 / 000. ALUOp=01 -> 110 for any func.
- mult, src_a=0xFFFFFFFE (-2), src_b=0x00000003 -> md_done at start+34 clocks; HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div, src_a=-7, src_b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 -> LO=0xFFFFFFFF, HI=0x00000007. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- mflo held with op_valid=1 immediately after div start -> stall=1 for 34 cycles, then hilo_rdata=new LO. An interleaved add during RUN -> stall=0, ALUControl=010.
- mthi 0x12345678 then mfhi in IDLE -> hilo_rdata=0x12345678. mthi presented while busy -> stalled, HI unchanged until the engine returns to IDLE.
- rst_n pulsed low in RUN cycle 10 -> md_busy=0 and HI=LO=0 immediately; no md_done. A fresh mult after release completes normally.
